// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
// Parametrised multiplexed seven-segment display driver. Scans DIGITS digits,
// holding each for PRESCALE clocks, with hex/BCD glyph selection, leading-zero
// blanking, per-digit decimal points, PWM brightness and a double-buffered
// digit store that only changes at frame boundaries (tear-free).
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset (blanks the display at once)
//   load       single-cycle strobe capturing digits_in/dp_in into pending
//   digits_in  nibble i = value of digit i (digit 0 rightmost)
//   dp_in      bit i = 1 lights the decimal point of digit i
//   hex_mode   1: values 10-15 show A-F, 0: values 10-15 blank
//   lz_blank   1: blank leading zeros (digit 0 never blanked)
//   bright     on-time = (bright+1)/2^BRIGHT_BITS of each slot
//   seg        active-low cathodes, seg[0]=a .. seg[6]=g
//   dp         active-low decimal point
//   an         active-low anodes, at most one low
//   frame_tick one-cycle pulse at each frame start
module sseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int PRESCALE    = 16384,
  parameter int BRIGHT_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [4*DIGITS-1:0]    digits_in,
  input  logic [DIGITS-1:0]      dp_in,
  input  logic                   hex_mode,
  input  logic                   lz_blank,
  input  logic [BRIGHT_BITS-1:0] bright,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [DIGITS-1:0]      an,
  output logic                   frame_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]          presc;
  logic [IW-1:0]          idx;
  logic [BRIGHT_BITS-1:0] pwm_cnt;
  logic [4*DIGITS-1:0]    pend_dig;
  logic [4*DIGITS-1:0]    disp_dig;
  logic [DIGITS-1:0]      pend_dp;
  logic [DIGITS-1:0]      disp_dp;

  logic                   slot_end;
  logic                   frame_end;
  logic [DIGITS-1:0]      lead_zero;
  logic                   zero_run;
  logic [3:0]             cur_nib;
  logic [6:0]             seg_next;
  logic [DIGITS-1:0]      an_next;
  logic                   dp_next;

  function automatic logic [6:0] glyph(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    if (!hex && (v > 4'd9)) g = 7'b1111111;
    return g;
  endfunction

  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot prescaler, scan index and free-running PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_BITS'(1);
      if (slot_end) begin
        presc <= '0;
        idx   <= frame_end ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Double buffer: display copies pending only at the frame boundary, so a
  // load on that same edge goes to pending and shows one frame later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dig   <= '0;
      pend_dp    <= '0;
      disp_dig   <= '0;
      disp_dp    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (frame_end) begin
        disp_dig <= pend_dig;
        disp_dp  <= pend_dp;
      end
      if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
      end
    end
  end

  // lead_zero[i] is set when digit i and every higher digit are zero.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_dig[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib  = disp_dig[{idx, 2'b00} +: 4];
    an_next  = '1;
    seg_next = 7'b1111111;
    dp_next  = 1'b1;
    if (pwm_cnt <= bright) begin
      an_next[idx] = 1'b0;
      dp_next      = ~disp_dp[idx];
      if (lz_blank && (idx != '0) && lead_zero[idx])
        seg_next = 7'b1111111;
      else
        seg_next = glyph(cur_nib, hex_mode);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'b1111111;
      an  <= '1;
      dp  <= 1'b1;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver
// Self-checking bench for sseg_scan_driver (DIGITS=4, PRESCALE=4,
// BRIGHT_BITS=2). A cycle-count model derives the expected outputs; directed
// checks pin specific glyphs, timing and reset behaviour.
module tb_sseg_scan_driver;

  localparam int D     = 4;
  localparam int P     = 4;
  localparam int B     = 2;
  localparam int FRAME = P * D;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        load      = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in     = '0;
  logic        hex_mode  = 1'b0;
  logic        lz_blank  = 1'b0;
  logic [1:0]  bright    = 2'd3;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int tests = 0;
  int fails = 0;

  // Model state: t counts clock edges since reset release.
  int          t         = 0;
  logic [15:0] m_pend    = '0;
  logic [15:0] m_disp    = '0;
  logic [3:0]  m_pend_dp = '0;
  logic [3:0]  m_disp_dp = '0;
  logic [3:0]  exp_an    = 4'hF;
  logic [6:0]  exp_seg   = 7'h7F;
  logic        exp_dp    = 1'b1;
  logic        exp_tick  = 1'b0;

  sseg_scan_driver #(.DIGITS(D), .PRESCALE(P), .BRIGHT_BITS(B)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .hex_mode(hex_mode), .lz_blank(lz_blank), .bright(bright),
    .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyphOf(input logic [3:0] v, input logic hex);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      default: ;
    endcase
    if (!hex) return 7'b1111111;
    case (v)
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic int idxOf(input int tc);
    return (tc / P) % D;
  endfunction

  function automatic logic pwmOn(input int tc, input logic [1:0] br);
    return (tc % (1 << B)) <= int'(br);
  endfunction

  function automatic logic [6:0] expSeg(input int tc, input logic [15:0] disp,
                                        input logic hex, input logic lz);
    int k;
    k = idxOf(tc);
    if (lz && k > 0 && ((disp >> (4 * k)) == 16'd0)) return 7'h7F;
    return glyphOf(4'(disp >> (4 * k)), hex);
  endfunction

  // Expected outputs appear one edge after the state that selects them.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t         <= 0;
      m_pend    <= '0;
      m_disp    <= '0;
      m_pend_dp <= '0;
      m_disp_dp <= '0;
      exp_an    <= 4'hF;
      exp_seg   <= 7'h7F;
      exp_dp    <= 1'b1;
      exp_tick  <= 1'b0;
    end else begin
      exp_an   <= pwmOn(t, bright) ? ~(4'b0001 << idxOf(t)) : 4'hF;
      exp_seg  <= pwmOn(t, bright) ? expSeg(t, m_disp, hex_mode, lz_blank) : 7'h7F;
      exp_dp   <= pwmOn(t, bright) ? ~m_disp_dp[idxOf(t)] : 1'b1;
      exp_tick <= (t % FRAME) == FRAME - 1;
      if ((t % FRAME) == FRAME - 1) begin
        m_disp    <= m_pend;
        m_disp_dp <= m_pend_dp;
      end
      if (load) begin
        m_pend    <= digits_in;
        m_pend_dp <= dp_in;
      end
      t <= t + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] dig,
                               input logic [3:0] dpv, input logic hx,
                               input logic lz, input logic [1:0] br);
    @(posedge clk);
    #1;
    load      = ld;
    digits_in = dig;
    dp_in     = dpv;
    hex_mode  = hx;
    lz_blank  = lz;
    bright    = br;
  endtask

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitTick(output int n);
    bit found;
    n = 0;
    found = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (frame_tick) found = 1;
    end
    if (!found) checkOutput("tick_timeout", 16'd0, 16'd1);
  endtask

  task automatic checkLit(input string name, input logic [3:0] ea,
                          input logic [6:0] es, input logic ed);
    checkOutput(name, {an, seg, dp}, {ea, es, ed});
  endtask

  initial begin
    fork
      begin : stimulus
        int n;
        int cnt0;
        int cntAny;
        // Reset and scan of zeros
        repeat (3) @(negedge clk);
        rst = 1'b0;
        advance(1);
        checkLit("rst_first_digit0", 4'b1110, 7'b1000000, 1'b1);
        advance(4);
        checkLit("rst_digit1", 4'b1101, 7'b1000000, 1'b1);
        waitTick(n);
        waitTick(n);
        checkOutput("tick_period", 16'(n), 16'd16);

        // Load 0305 with dp on digit 2, leading-zero blanking on
        applyStimulus(1'b1, 16'h0305, 4'b0100, 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b0, 16'h0305, 4'b0100, 1'b0, 1'b1, 2'd3);
        waitTick(n);
        advance(1);
        checkLit("d0305_dig0", 4'b1110, 7'b0010010, 1'b1);
        advance(4);
        checkLit("d0305_dig1", 4'b1101, 7'b1000000, 1'b1);
        advance(4);
        checkLit("d0305_dig2", 4'b1011, 7'b0110000, 1'b0);
        advance(4);
        checkLit("d0305_dig3", 4'b0111, 7'b1111111, 1'b1);

        // Hex glyphs, then hex off
        applyStimulus(1'b1, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 2'd3);
        waitTick(n);
        advance(1);
        checkLit("hex_F", 4'b1110, 7'b0001110, 1'b1);
        advance(4);
        checkLit("hex_E", 4'b1101, 7'b0000110, 1'b1);
        advance(8);
        checkLit("hex_b", 4'b0111, 7'b0000011, 1'b1);
        applyStimulus(1'b0, 16'hBEEF, 4'b0000, 1'b0, 1'b1, 2'd3);
        advance(2);
        checkOutput("hexoff_seg", 16'(seg), 16'h7F);
        checkOutput("hexoff_an_active", 16'(an != 4'hF), 16'd1);

        // Two loads in a frame, second on the boundary edge
        waitTick(n);
        applyStimulus(1'b1, 16'h1111, 4'b0000, 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b0, 16'h1111, 4'b0000, 1'b0, 1'b1, 2'd3);
        repeat (12) @(posedge clk);
        applyStimulus(1'b1, 16'h2222, 4'b0000, 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b0, 16'h2222, 4'b0000, 1'b0, 1'b1, 2'd3);
        advance(1);
        checkLit("frame_1111", 4'b1110, 7'b1111001, 1'b1);
        waitTick(n);
        advance(1);
        checkLit("frame_2222", 4'b1110, 7'b0100100, 1'b1);

        // PWM duty
        for (int br = 0; br < 2; br++) begin
          applyStimulus(1'b0, 16'h2222, 4'b0000, 1'b0, 1'b1, 2'(br));
          advance(2);
          cnt0 = 0;
          cntAny = 0;
          for (int c = 0; c < FRAME; c++) begin
            advance(1);
            if (an == 4'b1110) cnt0++;
            if (an != 4'hF) cntAny++;
          end
          checkOutput("pwm_digit0_on", 16'(cnt0), 16'(br + 1));
          checkOutput("pwm_total_on", 16'(cntAny), 16'(4 * (br + 1)));
        end

        // Reset in the middle of digit 2's slot
        applyStimulus(1'b0, 16'h2222, 4'b0000, 1'b0, 1'b0, 2'd3);
        waitTick(n);
        advance(9);
        checkLit("pre_rst_dig2", 4'b1011, 7'b0100100, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkLit("rst_immediate", 4'b1111, 7'b1111111, 1'b1);
        checkOutput("rst_tick", 16'(frame_tick), 16'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        advance(1);
        checkLit("post_rst_dig0", 4'b1110, 7'b1000000, 1'b1);
        advance(4);
        checkLit("post_rst_dig1", 4'b1101, 7'b1000000, 1'b1);
        waitTick(n);
        advance(1);
        checkLit("post_rst_pend_clear", 4'b1110, 7'b1000000, 1'b1);
        advance(3);
      end
      begin : compare
        forever begin
          @(negedge clk);
          checkOutput("cycle_outputs", {3'b000, an, seg, dp, frame_tick},
                      {3'b000, exp_an, exp_seg, exp_dp, exp_tick});
          checkOutput("onehot_anode", 16'($countones(~an) <= 1), 16'd1);
        end
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
